// File: rtl/nar_pkg.sv
// Shared fixed-point widths, feeder state encoding and address-width helper
// for the neuron feeder slice.
package nar_pkg;

  localparam int NAR_N = 10;
  localparam int NAR_Q = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    STREAM  = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4,
    HOLD    = 3'd5
  } feeder_state_t;

  // A single-entry buffer still gets a 1-bit address port.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nf_vec_buf.sv
// NUM_IN x N register file: one write port, one registered read port whose
// output register clears on reset or when no read is requested.
module nf_vec_buf #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;
  logic [W-1:0] rd_data_d;

  always_comb begin
    rd_data_d = '0;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/neuron_feeder.sv
// Sequencer feeding one MAC neuron: loads x/w vectors, clears the neuron, streams
// pairs, waits for the bias fold, captures the result. Optional NEURON_FEEDER_RELU_EN.
module neuron_feeder
  import nar_pkg::*;
#(
  parameter int  N      = NAR_N,
  parameter int  Q      = NAR_Q,
  parameter int  NUM_IN = 8,
  localparam int AW     = addr_w(NUM_IN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  input  logic [N-1:0]  bias_in,
  input  logic          start,
  output logic          busy,
  output logic          n_rst,
  output logic          n_valid,
  output logic [N-1:0]  n_w,
  output logic [N-1:0]  n_x,
  output logic [N-1:0]  n_b,
  input  logic [N-1:0]  n_out,
  output logic [N-1:0]  res,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_IN - 1);

  if (Q >= N || NUM_IN < 1) begin : g_cfg_err
    $error("neuron_feeder: need Q < N and NUM_IN >= 1");
  end

  feeder_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  n_b_q, n_b_d;
  logic [N-1:0]  cap_val;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          ld_ok;

`ifdef NEURON_FEEDER_RELU_EN
  assign cap_val = n_out[N-1] ? '0 : n_out;
`else
  assign cap_val = n_out;
`endif

  // Writes are only taken in IDLE so the vectors stay frozen for a whole run.
  assign ld_ok = ld_en && !rst && (state_q == IDLE) &&
                 ({1'b0, ld_addr} < (AW+1)'(NUM_IN));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    n_b_d   = n_b_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          idx_d   = '0;
          n_b_d   = bias_in;
        end
      end
      CLR: begin
        state_d = STREAM;
        idx_d   = '0;
        rd_en   = 1'b1;
      end
      STREAM: begin
        // Read address runs one ahead so the registered read lines up with n_valid.
        if (idx_q == LAST_IDX) begin
          state_d = SETTLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
          rd_en = 1'b1;
        end
      end
      SETTLE: begin
        if (idx_q == AW'(1)) begin
          state_d = CAPTURE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      CAPTURE: begin
        res_d   = cap_val;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    rd_addr = idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      res_q   <= '0;
      n_b_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      n_b_q   <= n_b_d;
    end
  end

  nf_vec_buf #(
    .W     (N),
    .DEPTH (NUM_IN),
    .AW    (AW)
  ) u_x_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ld_ok && !ld_sel),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (n_x)
  );

  nf_vec_buf #(
    .W     (N),
    .DEPTH (NUM_IN),
    .AW    (AW)
  ) u_w_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ld_ok && ld_sel),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (n_w)
  );

  assign busy      = (state_q != IDLE);
  assign n_rst     = rst || (state_q == CLR);
  assign n_valid   = (state_q == STREAM);
  assign n_b       = n_b_q;
  assign res       = res_q;
  assign res_valid = (state_q == HOLD);

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder (N=10, Q=9, NUM_IN=4) with a behavioural
// MAC neuron attached; honours NEURON_FEEDER_RELU_EN in its expected values.
module tb_neuron_feeder;

  localparam int N      = 10;
  localparam int NUM_IN = 4;
  localparam int AW     = 2;
`ifdef NEURON_FEEDER_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_en = 1'b0;
  logic          ld_sel = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [N-1:0]  ld_data = '0;
  logic [N-1:0]  bias_in = '0;
  logic          start = 1'b0;
  logic          busy, n_rst, n_valid, res_valid;
  logic [N-1:0]  n_w, n_x, n_b, n_out, res;
  logic          res_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] got_w [NUM_IN];
  logic [N-1:0] got_x [NUM_IN];

  always #5 clk = ~clk;

  neuron_feeder #(.N(N), .Q(9), .NUM_IN(NUM_IN)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .bias_in(bias_in), .start(start), .busy(busy),
    .n_rst(n_rst), .n_valid(n_valid), .n_w(n_w), .n_x(n_x), .n_b(n_b),
    .n_out(n_out), .res(res), .res_valid(res_valid), .res_ready(res_ready)
  );

  // Behavioural neuron: Q9 products accumulated, bias added, saturated to 10 bits.
  logic signed [31:0] acc_q, prod_ext, acc_sh, b_ext, sum;
  assign prod_ext = $signed(n_w) * $signed(n_x);
  assign acc_sh   = acc_q >>> 9;
  assign b_ext    = $signed(n_b);
  assign sum      = acc_sh + b_ext;
  assign n_out    = (sum > 511) ? 10'h1FF : (sum < -512) ? 10'h200 : sum[9:0];

  always_ff @(posedge clk) begin
    if (n_rst) acc_q <= '0;
    else if (n_valid) acc_q <= acc_q + prod_ext;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_vec(input logic sel, input logic [N-1:0] v0, v1, v2, v3);
    logic [N-1:0] vals [NUM_IN];
    vals = '{v0, v1, v2, v3};
    for (int i = 0; i < NUM_IN; i++) begin
      ld_en = 1'b1; ld_sel = sel; ld_addr = AW'(i); ld_data = vals[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  // One evaluation: start in cycle t, expects res_valid in cycle t+9 with four pairs.
  task automatic run(input string tag, input logic [N-1:0] bias, input logic [N-1:0] exp_res,
                     input int hold, input bit ld_w0_384, input bit poke);
    int lat;
    int nv;
    bias_in = bias;
    start = 1'b1;
    if (ld_w0_384) begin
      ld_en = 1'b1; ld_sel = 1'b1; ld_addr = '0; ld_data = 10'd384;
    end
    @(negedge clk);
    start = 1'b0;
    ld_en = 1'b0;
    chk({tag, "_clr_busy"}, busy, 1);
    chk({tag, "_clr_nrst"}, n_rst, 1);
    lat = 1;
    nv = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (n_valid === 1'b1) begin
        if (nv < NUM_IN) begin
          got_w[nv] = n_w;
          got_x[nv] = n_x;
        end
        nv++;
      end
      if (poke && lat == 2) begin
        ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 2'd3; ld_data = 10'h300;
      end
      if (poke && lat == 3) ld_en = 1'b0;
    end
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_pairs"}, nv, NUM_IN);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_nb"}, n_b, bias);
    chk({tag, "_hold_nw"}, n_w, 0);
    for (int k = 0; k < hold; k++) begin
      start = (k == 3);
      @(negedge clk);
      chk({tag, "_hold_valid"}, res_valid, 1);
      chk({tag, "_hold_res"}, res, exp_res);
    end
    res_ready = 1'b1;
    start = (hold > 0);
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    chk({tag, "_ack_valid"}, res_valid, 0);
    chk({tag, "_ack_busy"}, busy, 0);
    chk({tag, "_ack_res"}, res, exp_res);
    $display("run %s: res=%0h latency=%0d pairs=%0d", tag, res, lat, nv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_nvalid", n_valid, 0);
    chk("rst_nw", n_w, 0);
    chk("rst_nx", n_x, 0);
    chk("rst_nb", n_b, 0);
    chk("rst_res", res, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_nrst", n_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_nrst", n_rst, 0);
    $display("reset checks done");

    // 0.5 * 0.25 summed over 4 entries = 0.5
    load_vec(1'b0, 10'd256, 10'd256, 10'd256, 10'd256);
    load_vec(1'b1, 10'd128, 10'd128, 10'd128, 10'd128);
    run("half", 10'd0, 10'd256, 0, 1'b0, 1'b0);
    chk("half_w0", got_w[0], 10'd128);
    chk("half_x3", got_x[3], 10'd256);

    // Negative result, or zero through the ReLU
    load_vec(1'b1, 10'h380, 10'h380, 10'h380, 10'h380);
    run("neg", 10'd0, RELU ? 10'd0 : 10'h300, 0, 1'b0, 1'b0);

    // Distinct entries: order of the stream and bias fold (96 + 32)
    load_vec(1'b0, 10'd256, 10'd128, 10'h300, 10'd64);
    load_vec(1'b1, 10'd256, 10'd256, 10'd256, 10'd256);
    run("order", 10'd32, 10'd128, 0, 1'b0, 1'b0);
    chk("order_x0", got_x[0], 10'd256);
    chk("order_x1", got_x[1], 10'd128);
    chk("order_x2", got_x[2], 10'h300);
    chk("order_x3", got_x[3], 10'd64);

    // Positive saturation with a 10-cycle stall, start pulse in HOLD, start at handshake
    load_vec(1'b0, 10'd511, 10'd511, 10'd511, 10'd511);
    load_vec(1'b1, 10'd511, 10'd511, 10'd511, 10'd511);
    run("satpos", 10'd0, 10'h1FF, 10, 1'b0, 1'b0);

    // Negative saturation
    load_vec(1'b1, 10'h200, 10'h200, 10'h200, 10'h200);
    run("satneg", 10'd0, RELU ? 10'd0 : 10'h200, 0, 1'b0, 1'b0);

    // Write to w[0] in the start cycle lands before the read: 384
    load_vec(1'b0, 10'd256, 10'd256, 10'd256, 10'd256);
    load_vec(1'b1, 10'd128, 10'd128, 10'd128, 10'd128);
    run("ldstart", 10'd0, 10'd384, 0, 1'b1, 1'b0);
    load_vec(1'b1, 10'd128, 10'd128, 10'd128, 10'd128);

    // Reset in the second STREAM cycle
    bias_in = 10'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_streaming", n_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_nrst", n_rst, 1);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_nvalid", n_valid, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_nw", n_w, 0);
    chk("midrst_res", res, 0);
    rst = 1'b0;
    @(negedge clk);
    $display("mid-run reset done");
    run("after_rst", 10'd0, 10'd256, 0, 1'b0, 1'b0);

    // Loads during STREAM are dropped, for this run and the next
    run("poke", 10'd0, 10'd256, 0, 1'b0, 1'b1);
    run("post_poke", 10'd0, 10'd256, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
